// File: rtl/fft_peak_finder_if.sv
// Port bundle for fft_peak_finder: magnitude/phase bins in, peak report out.
// dbg_scan exposes the scanner FSM state (1 = SCAN) for checkers.
interface fft_peak_finder_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 10
);
    // Valid-only stream, no backpressure: a bin is transferred on every
    // rising clk edge where i_vld is high; o_vld/o_abort are single-cycle pulses.
    logic                    i_vld;
    logic                    i_sof;
    logic signed [WIDTH-1:0] i_mag;
    logic signed [31:0]      i_phase;
    logic                    o_vld;
    logic [IDX_W-1:0]        o_idx;
    logic signed [WIDTH-1:0] o_mag;
    logic signed [31:0]      o_phase;
    logic                    o_abort;
    logic                    dbg_scan;

    modport master (
        output i_vld, i_sof, i_mag, i_phase,
        input  o_vld, o_idx, o_mag, o_phase, o_abort, dbg_scan
    );

    modport slave (
        input  i_vld, i_sof, i_mag, i_phase,
        output o_vld, o_idx, o_mag, o_phase, o_abort, dbg_scan
    );
endinterface

// File: rtl/fft_peak_finder.sv
// Per-frame peak search over NBINS CORDIC magnitude/phase bins.
// Define PEAK_GAIN_COMP_EN to scale the reported magnitude by ~1/1.6468 (one extra stage).
module fft_peak_finder #(
    parameter int WIDTH   = 32,
    parameter int NBINS   = 1024,
    parameter int IDX_W   = $clog2(NBINS),
    parameter int MIN_BIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    fft_peak_finder_if.slave   bus
);
    localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(MIN_BIN);
    localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             accept, first, abort;
    logic [IDX_W-1:0] cnt_q, bin, idx_q, base_idx, new_idx;
    logic [WIDTH-1:0] max_q, mag_c, base_max, new_max;
    logic [31:0]      phase_q, base_phase, new_phase;
    logic             upd, last;

    logic             res_vld, abort_q;
    logic [IDX_W-1:0] res_idx;
    logic [WIDTH-1:0] res_mag;
    logic [31:0]      res_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        first   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_vld && bus.i_sof) begin
                    state_d = SCAN;
                    accept  = 1'b1;
                    first   = 1'b1;
                end
            end
            SCAN: begin
                if (bus.i_vld) begin
                    accept = 1'b1;
                    first  = bus.i_sof || (cnt_q == '0);
                    abort  = bus.i_sof && (cnt_q != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A frame start seeds the comparison with max 0 at MIN_BIN, so the
    // incoming bin 0 still competes when MIN_BIN is 0.
    always_comb begin
        bin        = first ? '0 : cnt_q;
        mag_c      = bus.i_mag[WIDTH-1] ? '0 : bus.i_mag;
        base_max   = first ? '0 : max_q;
        base_idx   = first ? MIN_IDX : idx_q;
        base_phase = first ? '0 : phase_q;
        upd        = (bin >= MIN_IDX) && (mag_c > base_max);
        new_max    = upd ? mag_c : base_max;
        new_idx    = upd ? bin : base_idx;
        new_phase  = upd ? bus.i_phase : base_phase;
        last       = accept && (&bin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            phase_q   <= '0;
            res_vld   <= 1'b0;
            res_idx   <= '0;
            res_mag   <= '0;
            res_phase <= '0;
            abort_q   <= 1'b0;
        end else begin
            res_vld <= last;
            abort_q <= abort;
            if (accept) begin
                cnt_q   <= bin + 1'b1;
                max_q   <= new_max;
                idx_q   <= new_idx;
                phase_q <= new_phase;
            end
            if (last) begin
                res_idx   <= new_idx;
                res_mag   <= new_max;
                res_phase <= new_phase;
            end
        end
    end

`ifdef PEAK_GAIN_COMP_EN
    localparam logic [15:0] K_GAIN = 16'd19899;

    logic [WIDTH+15:0] prod;
    logic [WIDTH:0]    scaled;
    logic [WIDTH-1:0]  comp_mag;
    logic              unused_prod_lsbs;
    logic              g_vld;
    logic [IDX_W-1:0]  g_idx;
    logic [WIDTH-1:0]  g_mag;
    logic [31:0]       g_phase;

    // res_mag is never negative, so an unsigned multiply matches the signed one.
    assign prod             = {16'b0, res_mag} * {{WIDTH{1'b0}}, K_GAIN};
    assign scaled           = prod[WIDTH+15:15];
    assign comp_mag         = (scaled[WIDTH] | scaled[WIDTH-1]) ? MAG_MAX : scaled[WIDTH-1:0];
    assign unused_prod_lsbs = ^prod[14:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_vld   <= 1'b0;
            g_idx   <= '0;
            g_mag   <= '0;
            g_phase <= '0;
        end else begin
            g_vld <= res_vld;
            if (res_vld) begin
                g_idx   <= res_idx;
                g_mag   <= comp_mag;
                g_phase <= res_phase;
            end
        end
    end

    assign bus.o_vld   = g_vld;
    assign bus.o_idx   = g_idx;
    assign bus.o_mag   = g_mag;
    assign bus.o_phase = g_phase;
`else
    assign bus.o_vld   = res_vld;
    assign bus.o_idx   = res_idx;
    assign bus.o_mag   = res_mag;
    assign bus.o_phase = res_phase;
`endif

    assign bus.o_abort  = abort_q;
    assign bus.dbg_scan = (state_q == SCAN);
endmodule
